// File: rtl/display_scan_pkg.sv
// rtl/display_scan_pkg.sv - shared constants and types for the display scanner
// Purpose: character codes for the non-hex glyphs, the blank segment pattern,
//          the blink phase type and the digit-enable helper.
// Ports:   none (package)
package display_scan_pkg;

  localparam logic [4:0] CH_P     = 5'h10;
  localparam logic [4:0] CH_DASH  = 5'h11;
  localparam logic [4:0] CH_L     = 5'h12;
  localparam logic [4:0] CH_N     = 5'h13;
  localparam logic [4:0] CH_R     = 5'h14;
  localparam logic [4:0] CH_BLANK = 5'h1F;

  // Segments are active-low {g,f,e,d,c,b,a}; all ones turns every segment off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } blink_phase_e;

  // Index 0 is the leftmost character, which is wired to an[3].
  function automatic logic [3:0] digit_enable(input logic [1:0] idx);
    return ~(4'b1000 >> idx);
  endfunction

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational 5-bit character code to 7-segment decoder
// Purpose: maps hex digits and a few letters/symbols to active-low segments.
// Ports:   code [4:0] in  - character code (0x00-0x0F hex, 0x10-0x14 glyphs)
//          seg  [6:0] out - active-low segments {g,f,e,d,c,b,a}
module seg_decode
  import display_scan_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'h00:   seg = 7'b1000000;
      5'h01:   seg = 7'b1111001;
      5'h02:   seg = 7'b0100100;
      5'h03:   seg = 7'b0110000;
      5'h04:   seg = 7'b0011001;
      5'h05:   seg = 7'b0010010;
      5'h06:   seg = 7'b0000010;
      5'h07:   seg = 7'b1111000;
      5'h08:   seg = 7'b0000000;
      5'h09:   seg = 7'b0010000;
      5'h0A:   seg = 7'b0001000;
      5'h0B:   seg = 7'b0000011;
      5'h0C:   seg = 7'b1000110;
      5'h0D:   seg = 7'b0100001;
      5'h0E:   seg = 7'b0000110;
      5'h0F:   seg = 7'b0001110;
      CH_P:    seg = 7'b0001100;
      CH_DASH: seg = 7'b0111111;
      CH_L:    seg = 7'b1000111;
      CH_N:    seg = 7'b0101011;
      CH_R:    seg = 7'b0101111;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// rtl/display_scan.sv - 4-digit multiplexed 7-segment scanner with blink
// Purpose: time-multiplexes a 4-character word onto a common-anode display,
//          latching the word once per frame and optionally blinking it.
// Ports:   clk            in  - clock, rising edge
//          rst            in  - synchronous active-high reset
//          F        [19:0] in - packed characters, char0 in F[19:15]
//          blink_en       in  - alternate lit / blank every BLINK_FRAMES frames
//          an       [3:0] out - active-low digit enables, an[3] = char0
//          seg      [6:0] out - active-low segments {g,f,e,d,c,b,a}
module display_scan
  import display_scan_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] F,
  input  logic        blink_en,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] frm_q, frm_d;
  blink_phase_e  phase_q, phase_d;
  logic [19:0]   shadow_q, shadow_d;
  logic          cap_q, cap_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          tick;
  logic          wrap;
  logic [4:0]    cur_code;
  logic [6:0]    dec_seg;

  seg_decode u_seg_decode (
    .code (cur_code),
    .seg  (dec_seg)
  );

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    wrap  = tick && (idx_q == 2'd3);

    cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d = tick ? idx_q + 2'd1 : idx_q;

    // The word is only sampled at frame boundaries (and once right after
    // reset) so a frame never mixes characters from two different words.
    shadow_d = (cap_q || wrap) ? F : shadow_q;
    cap_d    = 1'b0;

    // Disabling blink parks the phase at "on" with a fresh count, so the next
    // enable begins with a full lit half-period.
    frm_d   = frm_q;
    phase_d = phase_q;
    if (!blink_en) begin
      frm_d   = '0;
      phase_d = PHASE_ON;
    end else if (wrap) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        frm_d = frm_q + FW'(1);
      end
    end

    case (idx_q)
      2'd0:    cur_code = shadow_q[19:15];
      2'd1:    cur_code = shadow_q[14:10];
      2'd2:    cur_code = shadow_q[9:5];
      default: cur_code = shadow_q[4:0];
    endcase

    if (blink_en && (phase_q == PHASE_OFF)) begin
      an_d  = 4'hF;
      seg_d = SEG_BLANK;
    end else begin
      an_d  = digit_enable(idx_q);
      seg_d = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      frm_q    <= '0;
      phase_q  <= PHASE_ON;
      shadow_q <= 20'hFFFFF;
      cap_q    <= 1'b1;
      an_q     <= 4'hF;
      seg_q    <= SEG_BLANK;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      frm_q    <= frm_d;
      phase_q  <= phase_d;
      shadow_q <= shadow_d;
      cap_q    <= cap_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - self-checking bench for display_scan
module tb_display_scan;

  localparam int DIV = 4;
  localparam int BF  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] F = 20'h0;
  logic        blink_en = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;

  always #5 clk = ~clk;

  display_scan #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk      (clk),
    .rst      (rst),
    .F        (F),
    .blink_en (blink_en),
    .an       (an),
    .seg      (seg)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: cycles since reset release, latched word, and the
  // number of frame ends seen while blink has been continuously enabled.
  int          n_m      = 0;
  logic [19:0] shadow_m = 20'hFFFFF;
  int          en_wraps = 0;
  bit          armed    = 1'b0;
  logic [3:0]  exp_an   = 4'hF;
  logic [6:0]  exp_seg  = 7'h7F;

  function automatic logic [6:0] seg_of(input logic [4:0] code);
    string lit;
    logic [6:0] s;
    case (code)
      5'h00: lit = "abcdef";
      5'h01: lit = "bc";
      5'h02: lit = "abdeg";
      5'h03: lit = "abcdg";
      5'h04: lit = "bcfg";
      5'h05: lit = "acdfg";
      5'h06: lit = "acdefg";
      5'h07: lit = "abc";
      5'h08: lit = "abcdefg";
      5'h09: lit = "abcdfg";
      5'h0A: lit = "abcefg";
      5'h0B: lit = "cdefg";
      5'h0C: lit = "adef";
      5'h0D: lit = "bcdeg";
      5'h0E: lit = "adefg";
      5'h0F: lit = "aefg";
      5'h10: lit = "abefg";
      5'h11: lit = "g";
      5'h12: lit = "def";
      5'h13: lit = "ceg";
      5'h14: lit = "eg";
      default: lit = "";
    endcase
    s = 7'h7F;
    for (int i = 0; i < lit.len(); i++) s[int'(lit[i]) - 97] = 1'b0;
    return s;
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] want);
    checks++;
    assert (got === want)
    else begin
      failures++;
      $error("FAIL %s got=%b want=%b t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic step(input logic r, input logic [19:0] f, input logic be);
    int       digit;
    bit       wrap;
    logic [4:0] ch;
    rst      = r;
    F        = f;
    blink_en = be;
    @(posedge clk);
    if (r) begin
      exp_an   = 4'hF;
      exp_seg  = 7'h7F;
      n_m      = 0;
      shadow_m = 20'hFFFFF;
      en_wraps = 0;
      armed    = 1'b1;
    end else begin
      digit = (n_m / DIV) % 4;
      ch    = shadow_m[19 - 5*digit -: 5];
      if (be && ((en_wraps / BF) % 2 == 1)) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
      end else begin
        exp_an = 4'hF;
        exp_an[3 - digit] = 1'b0;
        exp_seg = seg_of(ch);
      end
      wrap = ((n_m % (4*DIV)) == 4*DIV - 1);
      if (n_m == 0 || wrap) shadow_m = f;
      if (!be) en_wraps = 0;
      else if (wrap) en_wraps++;
      n_m++;
    end
    #1;
    if (armed) begin
      check("an", {3'b000, an}, {3'b000, exp_an});
      check("seg", seg, exp_seg);
    end
  endtask

  logic [19:0] w_scan;
  logic [19:0] w_codes;
  logic [19:0] w_rand;
  logic        be_rand;

  initial begin
    w_scan  = {5'h01, 5'h02, 5'h03, 5'h04};
    w_codes = {5'h10, 5'h11, 5'h12, 5'h1F};

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b1, w_scan, 1'b0);
    check("reset_an", {3'b000, an}, 7'h0F);
    check("reset_seg", seg, 7'h7F);

    // Scan order, char0 shows '1' on an=0111 once the word is latched
    for (int i = 0; i < 34; i++) begin
      step(1'b0, w_scan, 1'b0);
      if (i == 2) begin
        check("scan_an0", {3'b000, an}, 7'b0000111);
        check("scan_seg1", seg, 7'b1111001);
      end
    end

    // No tearing: change the word in the middle of a frame
    for (int i = 0; i < 4; i++) step(1'b0, w_scan, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 20'h00000, 1'b0);
    check("zero_seg", seg, 7'b1000000);

    // Blink from a fresh reset
    step(1'b1, 20'h00000, 1'b1);
    for (int i = 0; i < 140; i++) begin
      step(1'b0, 20'h00000, 1'b1);
      if (i == 40) begin
        check("blink_off_an", {3'b000, an}, 7'h0F);
        check("blink_off_seg", seg, 7'h7F);
      end
    end

    // Special glyph codes
    step(1'b1, w_codes, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, w_codes, 1'b0);

    // Reset during digit 2
    for (int i = 0; i < 16 && ((n_m / DIV) % 4) != 2; i++) step(1'b0, w_scan, 1'b0);
    check("reached_digit2", 7'((n_m / DIV) % 4), 7'd2);
    step(1'b1, w_scan, 1'b0);
    check("midrst_an", {3'b000, an}, 7'h0F);
    check("midrst_seg", seg, 7'h7F);
    for (int i = 0; i < 24; i++) step(1'b0, w_codes, 1'b0);

    // Randomized stimulus
    w_rand  = $urandom();
    be_rand = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) w_rand = $urandom();
      if ($urandom_range(0, 149) == 0) be_rand = ~be_rand;
      step(($urandom_range(0, 399) == 0), w_rand, be_rand);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clk cycles each digit stays lit; legal range 2..2^20.
REQ-002 Parameter BLINK_FRAMES, default 125: number of completed scan frames per blink half-period; legal range 1..2^16.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 F  input  20  packed 4-character display word: char0 = F[19:15] (leftmost), char1 = F[14:10], char2 = F[9:5], char3 = F[4:0].
REQ-006 blink_en  input  1  when high, the display alternates between lit and blank.
REQ-007 an  output  4  active-low digit enables: an[3] = char0, an[2] = char1, an[1] = char2, an[0] = char3.
REQ-008 seg  output  7  active-low segments ordered {g,f,e,d,c,b,a}.

Function
REQ-009 Prescaler counts 0..REFRESH_DIV-1 and wraps; the tick is asserted in the cycle the count equals REFRESH_DIV-1.
REQ-010 2-bit digit index advances 0->1->2->3->0 on each tick; index 0 selects char0.
REQ-011 Shadow register captures F in the first cycle after reset release, and on every tick where the index wraps 3->0; F is ignored at all other times (no tearing within a frame).
REQ-012 an and seg are registered and follow the index and shadow with one cycle of latency; exactly one an bit is low when lit.
REQ-013 Character decode: codes 0x00-0x0F = hex 0-F; 0x10 = 'P'; 0x11 = '-' (g only); 0x12 = 'L'; 0x13 = 'n'; 0x14 = 'r'; codes 0x15-0x1F = blank (seg = 7'h7F).
REQ-014 Required patterns: '0' = 7'b1000000, '1' = 7'b1111001, '8' = 7'b0000000, '-' = 7'b0111111, 'P' = 7'b0001100, 'L' = 7'b1000111.
REQ-015 Frame counter increments on each 3->0 wrap; on reaching BLINK_FRAMES it clears and toggles the blink phase.
REQ-016 When blink_en is high and the blink phase is "off", an = 4'hF and seg = 7'h7F; the scan, shadow capture and counters continue unchanged.
REQ-017 When blink_en is low, the blink phase is forced to "on" and the frame counter is held at 0, so a later enable always starts with a full lit half-period.
REQ-018 blink_en is sampled every cycle; the output change appears with the REQ-012 latency, even mid-frame.
REQ-019 If the 3->0 wrap and the blink toggle occur on the same tick, the new phase applies starting with digit 0 of the new frame.

Reset
REQ-020 While rst is high: prescaler = 0, index = 0, frame counter = 0, blink phase = on, shadow = 20'hFFFFF, an = 4'hF, seg = 7'h7F.
REQ-021 Assertion of rst mid-digit or mid-frame takes effect on the next edge and discards all scan progress.
REQ-022 After rst falls, char0 from the newly captured F is driven one cycle after the capture.

Structure
REQ-023 Shared package holds the character code constants (CH_P, CH_DASH, CH_L, CH_N, CH_R, CH_BLANK = 5'h1F) and the SEG_BLANK = 7'h7F constant.
REQ-024 Sub-module seg_decode is a purely combinational 5-bit code to 7-bit active-low segment decoder, instantiated once.

Verification (REFRESH_DIV = 4, BLINK_FRAMES = 2)
REQ-025 Scan order: F = {5'h01,5'h02,5'h03,5'h04}, blink_en = 0 -> an cycles 0111, 1011, 1101, 1110, each for 4 clk; seg = 1111001 while an = 0111.
REQ-026 No tearing: change F mid-frame to 20'h00000 -> the old characters are held until the 3->0 wrap; the next frame shows '0' on all digits (seg = 1000000).
REQ-027 Blink: F = 20'h00000, blink_en = 1 -> 2 frames (32 clk) lit, then 32 clk with an = 1111 and seg = 7F, repeating.
REQ-028 Codes: F = {5'h10,5'h11,5'h12,5'h1F} -> seg = 0001100, 0111111, 1000111, 1111111 on the successive digits.
REQ-029 Reset mid-frame: assert rst during digit 2 for 1 cycle -> next cycle an = 1111 and seg = 7F; scan restarts at digit 0 with F recaptured.
